seg7_scan_display: RTL

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit packed-BCD/hex word produced by the button-editing stage, with digit k in bits [4k+3:4k]. It scans one digit at a time, with optional leading-zero blanking, a blinking cursor digit and per-digit decimal points. The data word is snapshotted once per frame so the display never shows a torn value.

---
 rtl/seg7_scan_display.sv | 115 +++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans one digit per slot from a frame-latched copy of the data word.
module seg7_scan_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic        blank_lz,
  input  logic [2:0]  cursor,
  input  logic        cursor_en,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [2:0]       dig_q;
  logic [31:0]      frm_q;
  logic [7:0]       dpf_q;
  logic [BLK_W-1:0] bc_q;
  logic             ph_q;

  logic       div_last_c;
  logic       blk_last_c;
  logic       lz_c;
  logic       cur_off_c;
  logic       lit_c;
  logic [3:0] nib_c;

  // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot decode: a digit is lit unless it is a leading zero, the blinking cursor, or the deghost cycle.
  always_comb begin
    div_last_c = (div_q == DIV_LAST);
    blk_last_c = (bc_q == BLK_LAST);
    nib_c      = frm_q[{dig_q, 2'b00} +: 4];
    lz_c       = blank_lz && (dig_q != 3'd0);
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) >= dig_q) && (frm_q[4*i +: 4] != 4'h0)) lz_c = 1'b0;
    end
    cur_off_c  = cursor_en && ph_q && (cursor == dig_q);
    lit_c      = !lz_c && !cur_off_c && (div_q != '0);
  end

  // Scan, frame-snapshot and blink counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      dig_q <= 3'd0;
      frm_q <= 32'h0;
      dpf_q <= 8'h0;
      bc_q  <= '0;
      ph_q  <= 1'b0;
    end else begin
      div_q <= div_last_c ? '0 : div_q + DIV_W'(1);
      if (div_last_c) begin
        dig_q <= dig_q + 3'd1;
        if (dig_q == 3'd7) begin
          frm_q <= data_i;
          dpf_q <= dp_i;
        end
      end
      bc_q <= blk_last_c ? '0 : bc_q + BLK_W'(1);
      if (blk_last_c) ph_q <= ~ph_q;
    end
  end

  // Registered pin drivers; everything dark when the slot is not lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o  <= 8'hFF;
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
    end else if (lit_c) begin
      an_o  <= ~(8'd1 << dig_q);
      seg_o <= hex7(nib_c);
      dp_o  <= ~dpf_q[dig_q];
    end else begin
      an_o  <= 8'hFF;
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
    end
  end

endmodule
